// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 16-bit words, then raises done.
// Latency: mem_we rises 1 cycle after the low-byte handshake; at best one word every 3 cycles.
// Backpressure: in_ready is high only while a byte is wanted; in_valid=0 stalls the current state indefinitely.
module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [15:0]       words_loaded,
    output logic              done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_DATA_LO = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Base address truncated to the memory width so the sum below wraps naturally.
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [15:0]       length;
    logic [7:0]        data_hi;
    logic [15:0]       words_inc;
    logic [ADDR_W-1:0] word_addr;
    logic              accept;
    logic              start_ok;

    // in_ready is itself a register that mirrors the byte-wanting states,
    // so the handshake qualifier carries no input-to-output path.
    assign accept    = in_valid & in_ready;
    assign start_ok  = start & ((state == S_IDLE) | (state == S_DONE));
    assign words_inc = words_loaded + 16'd1;
    assign word_addr = BASE_A + ADDR_W'(words_loaded);

    // Next-state selection: byte states advance only on a handshake, WRITE always lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI:       if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    state_nxt = ({length[15:8], in_data} != 16'd0) ? S_DATA_HI : S_DONE;
                end
            end
            S_DATA_HI:      if (accept) state_nxt = S_DATA_LO;
            S_DATA_LO:      if (accept) state_nxt = S_WRITE;
            S_WRITE:        state_nxt = (words_inc == length) ? S_DONE : S_DATA_HI;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // State plus the per-state status flags, registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                        (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO);
            mem_we   <= (state_nxt == S_WRITE);
            done     <= (state_nxt == S_DONE);
        end
    end

    // Capture the length prefix and the high byte of each word as they are accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            length  <= 16'd0;
            data_hi <= 8'd0;
        end else if (accept) begin
            if (state == S_LEN_HI)  length[15:8] <= in_data;
            if (state == S_LEN_LO)  length[7:0]  <= in_data;
            if (state == S_DATA_HI) data_hi      <= in_data;
        end
    end

    // Present the write word and address on the low-byte handshake; they hold until the next word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= 16'd0;
        end else if (accept && (state == S_DATA_LO)) begin
            mem_addr  <= word_addr;
            mem_wdata <= {data_hi, in_data};
        end
    end

    // Word counter: cleared when a new load starts, bumped as each WRITE cycle ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_loaded <= 16'd0;
        end else if (start_ok) begin
            words_loaded <= 16'd0;
        end else if (state == S_WRITE) begin
            words_loaded <= words_inc;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a default instance and a 4-bit-address instance based at 15 share stimulus.
// Expected writes come from a list model: word i of the stream lands at (BASE+i) mod 2^ADDR_W.
// Bytes are driven on the falling edge; outputs are sampled on the falling edge.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t [$];

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready, mem_we, done;
    logic [15:0] mem_addr, mem_wdata, words_loaded;

    logic        w_in_ready, w_mem_we, w_done;
    logic [3:0]  w_mem_addr;
    logic [15:0] w_mem_wdata, w_words_loaded;

    int checks = 0;
    int errors = 0;

    int wr_addr_q [$];
    int wr_data_q [$];
    int ww_addr_q [$];
    int ww_data_q [$];
    int we_rdy_bad = 0;
    int we_double = 0;
    int done_rdy_bad = 0;
    bit we_prev = 0;
    bit w_we_prev = 0;
    bit phase = 0;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .words_loaded(words_loaded), .done(done)
    );

    imem_loader #(.ADDR_W(4), .BASE_ADDR(15)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_in_ready), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .words_loaded(w_words_loaded), .done(w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe and track pulse-shape violations.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(int'(mem_wdata));
            if (in_ready !== 1'b0) we_rdy_bad++;
        end
        if (w_mem_we === 1'b1) begin
            ww_addr_q.push_back(int'(w_mem_addr));
            ww_data_q.push_back(int'(w_mem_wdata));
        end
        if (mem_we === 1'b1 && we_prev) we_double++;
        if (w_mem_we === 1'b1 && w_we_prev) we_double++;
        if (done === 1'b1 && in_ready === 1'b1) done_rdy_bad++;
        we_prev = (mem_we === 1'b1);
        w_we_prev = (w_mem_we === 1'b1);
    end

    task automatic clear_writes();
        wr_addr_q.delete(); wr_data_q.delete();
        ww_addr_q.delete(); ww_data_q.delete();
    endtask

    task automatic start_pulse();
        @(negedge clk);
        clear_writes();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer each byte until it is taken; with stall set, in_valid alternates 0/1 every cycle.
    task automatic send_bytes(input byte_q_t b, input bit stall);
        bit acc;
        int g;
        foreach (b[k]) begin
            acc = 1'b0;
            g = 0;
            while (!acc && g < 100) begin
                @(negedge clk);
                g++;
                if (stall && !phase) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data  = b[k];
                    acc = (in_ready === 1'b1);
                end
                if (stall) phase = !phase;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL handshake byte %0d: in_ready never high within 100 cycles", k);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Reference: word i = {b[2+2i], b[3+2i]} written at (BASE + i) mod 2^ADDR_W, one write per word.
    task automatic check_load(input string name, input byte_q_t b);
        int len;
        int waited;
        int exp_d;
        len = int'({b[0], b[1]});
        waited = 0;
        while (done !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b want 1", name, done); end
        checks++;
        if (w_done !== 1'b1) begin errors++; $display("FAIL %s wrap done: got %b want 1", name, w_done); end
        checks++;
        if (words_loaded !== 16'(len)) begin
            errors++; $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, len);
        end
        checks++;
        if (wr_addr_q.size() != len || ww_addr_q.size() != len) begin
            errors++;
            $display("FAIL %s write count: got %0d/%0d want %0d", name, wr_addr_q.size(), ww_addr_q.size(), len);
        end
        for (int i = 0; i < len; i++) begin
            exp_d = int'({b[2 + 2*i], b[3 + 2*i]});
            if (i < wr_addr_q.size()) begin
                checks++;
                if (wr_addr_q[i] != (i % 65536) || wr_data_q[i] != exp_d) begin
                    errors++;
                    $display("FAIL %s write %0d: got addr %0d data %h want addr %0d data %h",
                             name, i, wr_addr_q[i], wr_data_q[i], i % 65536, exp_d);
                end
            end
            if (i < ww_addr_q.size()) begin
                checks++;
                if (ww_addr_q[i] != ((15 + i) % 16) || ww_data_q[i] != exp_d) begin
                    errors++;
                    $display("FAIL %s wrap write %0d: got addr %0d data %h want addr %0d data %h",
                             name, i, ww_addr_q[i], ww_data_q[i], (15 + i) % 16, exp_d);
                end
            end
        end
    endtask

    task automatic test_reset();
        // Reset asserted together with start: reset must win.
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset flags: got rdy=%b we=%b done=%b want 0 0 0", in_ready, mem_we, done);
        end
        checks++;
        if (mem_addr !== 16'd0 || mem_wdata !== 16'd0 || words_loaded !== 16'd0) begin
            errors++; $display("FAIL reset regs: got addr=%h wdata=%h words=%h want 0", mem_addr, mem_wdata, words_loaded);
        end
        checks++;
        if (w_mem_addr !== 4'd0 || w_in_ready !== 1'b0 || w_done !== 1'b0) begin
            errors++; $display("FAIL reset wrap: got addr=%h rdy=%b done=%b want 0", w_mem_addr, w_in_ready, w_done);
        end
    endtask

    task automatic test_basic(input bit stall, input string name);
        byte_q_t q;
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        start_pulse();
        send_bytes(q, stall);
        check_load(name, q);
    endtask

    task automatic test_zero_length();
        byte_q_t q;
        q = '{8'h00, 8'h00};
        start_pulse();
        send_bytes(q, 1'b0);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_len done after 2 handshakes: got %b want 1", done); end
        check_load("zero_len", q);
    endtask

    task automatic test_wrap();
        byte_q_t q;
        q = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
        start_pulse();
        send_bytes(q, 1'b0);
        check_load("wrap", q);
    endtask

    task automatic test_reset_mid_load();
        byte_q_t q;
        q = '{8'h00, 8'h03, 8'hAA};
        start_pulse();
        send_bytes(q, 1'b0);
        // Reset edge coincides with a valid low byte: reset must win and no write may follow.
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hBB;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || words_loaded !== 16'd0) begin
            errors++; $display("FAIL midreset state: got rdy=%b we=%b done=%b words=%0d want idle",
                               in_ready, mem_we, done, words_loaded);
        end
        checks++;
        if (wr_addr_q.size() != 0 || ww_addr_q.size() != 0) begin
            errors++; $display("FAIL midreset writes: got %0d want 0", wr_addr_q.size());
        end
        q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        start_pulse();
        send_bytes(q, 1'b0);
        check_load("after_reset", q);
    endtask

    task automatic test_reload_ignored_start();
        byte_q_t q;
        byte_q_t q2;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL reload pre done: got %b want 1", done); end
        clear_writes();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || words_loaded !== 16'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reload clear: got done=%b words=%0d rdy=%b want 0 0 1", done, words_loaded, in_ready);
        end
        q = '{8'h00, 8'h02, 8'h11, 8'h22};
        send_bytes(q, 1'b0);
        // Hold start high while the loader waits in DATA_HI for the second word.
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        checks++;
        if (words_loaded !== 16'd1 || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL ignored start: got words=%0d rdy=%b done=%b want 1 1 0", words_loaded, in_ready, done);
        end
        q2 = '{8'h33, 8'h44};
        send_bytes(q2, 1'b0);
        q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        check_load("reload", q);
    endtask

    task automatic test_random();
        byte_q_t q;
        int len;
        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(1, 6);
            q = {};
            q.push_back(8'h00);
            q.push_back(8'(len));
            for (int j = 0; j < 2 * len; j++) q.push_back(8'($urandom));
            start_pulse();
            send_bytes(q, 1'($urandom_range(0, 1)));
            check_load($sformatf("random%0d", r), q);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (we_rdy_bad != 0) begin errors++; $display("FAIL in_ready during WRITE: got %0d cycles want 0", we_rdy_bad); end
        checks++;
        if (we_double != 0) begin errors++; $display("FAIL mem_we width: got %0d multi-cycle pulses want 0", we_double); end
        checks++;
        if (done_rdy_bad != 0) begin errors++; $display("FAIL done with in_ready: got %0d cycles want 0", done_rdy_bad); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_basic(1'b0, "basic");
        test_zero_length();
        test_basic(1'b1, "stall");
        test_wrap();
        test_reset_mid_load();
        test_reload_ignored_start();
        test_random();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of the instruction-memory write address.
REQ-002 SHALL have parameter BASE_ADDR, default 0, address at which the first loaded word is written.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port in_valid  input  1  in_data carries a byte.
REQ-007 SHALL have port in_data  input  8  program byte stream.
REQ-008 SHALL have port in_ready  output  1  loader will accept the byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  instruction-memory write address.
REQ-011 SHALL have port mem_wdata  output  16  instruction word to write.
REQ-012 SHALL have port words_loaded  output  16  count of words written in the current load.
REQ-013 SHALL have port done  output  1  load complete; also the CPU run enable.

Function
REQ-014 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE.
REQ-015 SHALL accept a byte only on a rising edge with in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready=1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
REQ-017 SHALL, in IDLE or DONE, move to LEN_HI on start=1; DONE->LEN_HI also clears done and words_loaded.
REQ-018 SHALL ignore start in LEN_HI, LEN_LO, DATA_HI, DATA_LO and WRITE.
REQ-019 SHALL capture the accepted byte as length[15:8] in LEN_HI, then go to LEN_LO.
REQ-020 SHALL capture length[7:0] in LEN_LO, then go to DATA_HI if length!=0, else directly to DONE.
REQ-021 SHALL capture the data byte as word[15:8] in DATA_HI, then go to DATA_LO.
REQ-022 SHALL capture word[7:0] in DATA_LO, then go to WRITE.
REQ-023 SHALL hold in WRITE for exactly one cycle with mem_we=1, mem_wdata={hi,lo} and mem_addr=(BASE_ADDR+words_loaded) mod 2^ADDR_W.
REQ-024 SHALL drive mem_we=0 in every state other than WRITE; mem_addr and mem_wdata hold their last values.
REQ-025 SHALL increment words_loaded at the end of WRITE, then go to DONE if the new value equals length, else DATA_HI.
REQ-026 SHALL drive all outputs from registers; no combinational path from any input to any output.
REQ-027 SHALL give a latency of 1 cycle from the DATA_LO handshake edge to mem_we=1. The minimum per-word throughput is 3 cycles.
REQ-028 SHALL keep each state unchanged while in_valid=0 (stalls of any length), with no spurious write.
REQ-029 SHALL wrap mem_addr modulo 2^ADDR_W when BASE_ADDR+index overflows. words_loaded does not wrap, since length<=65535.
REQ-030 SHALL drive done=1 only in DONE.

Reset
REQ-031 SHALL, on a rising edge with rst_n=0, enter IDLE. It SHALL also set in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, done=0 and clear length.
REQ-032 SHALL give reset priority over start and over any handshake on the same edge.
REQ-033 SHALL, on a mid-load reset, abort the load. A WRITE in progress completes only if its cycle precedes the reset edge, and no further writes occur.

Verification
REQ-034 SHALL check basic load: reset, start, bytes 00 02 12 34 AB CD at in_valid=1. Required: writes 0x1234 at addr 0 and 0xABCD at addr 1, each mem_we one cycle; done=1, words_loaded=2.
REQ-035 SHALL check zero length: start, bytes 00 00. Required: DONE reached after 2 handshakes, no mem_we pulse, done=1, words_loaded=0.
REQ-036 SHALL check stalls: the basic load with in_valid toggled 0/1 every cycle. Required: identical writes and addresses, in_ready=0 during each WRITE cycle.
REQ-037 SHALL check wrap: ADDR_W=4, BASE_ADDR=15, length 2 with words 0x0001 and 0x0002. Required: writes at mem_addr 15 then 0.
REQ-038 SHALL check reset mid-load: rst_n=0 after the first data byte of a length-3 load. Required: state IDLE, no mem_we, done=0; a new start followed by 00 01 BE EF writes 0xBEEF at addr 0.
REQ-039 SHALL check reload and ignored start: start in DONE, then start pulses during DATA_HI. Required: done clears the cycle after start, the mid-load start has no effect, and the second load overwrites from BASE_ADDR.
